// File: rtl/poly_slot_fifo.sv
// poly_slot_fifo
// Slot-granular FIFO of whole polynomials between pipeline stages. Each slot
// is a dual-port RAM of 2**ADDR_WIDTH lines x LINE_SIZE words. The producer
// opens the tail slot, writes it at random line addresses through ports A/B
// (per-word enables), then commits it. The consumer random-reads the head slot
// through ports A/B, then releases it.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   flush                     synchronous clear of pointers/count/open state/flags
//   wr_start, wr_commit       open tail slot / close and push the open slot
//   wr_open                   a tail slot is open for writing
//   weA/weB, waddrA/waddrB,
//   dinA/dinB                 write ports; word k at [k*BIT_WIDTH +: BIT_WIDTH]
//   full, empty, count        occupancy (committed, unreleased slots)
//   rd_en, raddrA/raddrB      read the head slot; data returns next cycle
//   rd_release                pop the head slot
//   doutA/doutB, rd_valid     registered read data and its valid strobe
//   err_ovf, err_udf          sticky overflow / underflow flags
//
// Write FSM
//   state     | meaning
//   ----------+---------------------------------------------------
//   ST_CLOSED | no slot open; writes are dropped
//   ST_OPEN   | slot[wr_ptr] open; writes land, wr_commit pushes it
module poly_slot_fifo #(
    parameter int BIT_WIDTH  = 32,
    parameter int LINE_SIZE  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 3,
    localparam int LW        = LINE_SIZE * BIT_WIDTH,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  wr_start,
    input  logic                  wr_commit,
    output logic                  wr_open,
    input  logic [LINE_SIZE-1:0]  weA,
    input  logic [LINE_SIZE-1:0]  weB,
    input  logic [ADDR_WIDTH-1:0] waddrA,
    input  logic [ADDR_WIDTH-1:0] waddrB,
    input  logic [LW-1:0]         dinA,
    input  logic [LW-1:0]         dinB,
    output logic                  full,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] raddrA,
    input  logic [ADDR_WIDTH-1:0] raddrB,
    input  logic                  rd_release,
    output logic [LW-1:0]         doutA,
    output logic [LW-1:0]         doutB,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic                  err_ovf,
    output logic                  err_udf
);

    localparam int PW    = $clog2(DEPTH);
    localparam int LINES = 2 ** ADDR_WIDTH;

    localparam logic [0:0] ST_CLOSED = 1'b0;
    localparam logic [0:0] ST_OPEN   = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_udf_q, err_udf_d;
    logic          rd_valid_q;
    logic [LW-1:0] douta_q, doutb_q;

    logic [LW-1:0] mem_q [DEPTH][LINES];

    logic full_w, empty_w;
    logic do_start, do_commit, do_release, do_read;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        // Explicit wrap so non-power-of-2 depths stay in 0..DEPTH-1.
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    assign do_start   = (state_q == ST_CLOSED) && wr_start && !full_w;
    assign do_commit  = (state_q == ST_OPEN) && wr_commit;
    assign do_release = rd_release && !empty_w;
    assign do_read    = rd_en && !empty_w;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;

        if (do_start) begin
            state_d = ST_OPEN;
        end
        if ((state_q == ST_CLOSED) && wr_start && full_w) begin
            err_ovf_d = 1'b1;
        end
        if (do_commit) begin
            state_d  = ST_CLOSED;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_release) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if ((rd_release || rd_en) && empty_w) begin
            err_udf_d = 1'b1;
        end

        // Commit needs count < DEPTH and release needs count > 0, so the
        // count stays inside 0..DEPTH without explicit saturation.
        case ({do_commit, do_release})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            state_q    <= ST_CLOSED;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            douta_q    <= '0;
            doutb_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
            rd_valid_q <= do_read;
            if (do_read) begin
                douta_q <= mem_q[rd_ptr_q][raddrA];
                doutb_q <= mem_q[rd_ptr_q][raddrB];
            end
        end
    end

    // RAM is not cleared by reset or flush. Port B is assigned after port A,
    // so it wins when both ports hit the same word of the same line.
    always_ff @(posedge clk) begin
        if (rstn && !flush && (state_q == ST_OPEN)) begin
            for (int k = 0; k < LINE_SIZE; k++) begin
                if (weA[k]) begin
                    mem_q[wr_ptr_q][waddrA][k*BIT_WIDTH +: BIT_WIDTH] <= dinA[k*BIT_WIDTH +: BIT_WIDTH];
                end
                if (weB[k]) begin
                    mem_q[wr_ptr_q][waddrB][k*BIT_WIDTH +: BIT_WIDTH] <= dinB[k*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end
    end

    assign wr_open  = (state_q == ST_OPEN);
    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_q;
    assign err_ovf  = err_ovf_q;
    assign err_udf  = err_udf_q;
    assign rd_valid = rd_valid_q;
    assign doutA    = douta_q;
    assign doutB    = doutb_q;

endmodule

// File: tb/tb_poly_slot_fifo.sv
// tb_poly_slot_fifo
// Directed bench for poly_slot_fifo (default parameters: 32-bit words,
// 4 words per line, 256 lines per slot, 3 slots). Inputs change 1 ns after
// the rising edge and outputs are sampled at that same point.
module tb_poly_slot_fifo;

    localparam int BW = 32;
    localparam int LS = 4;
    localparam int AW = 8;
    localparam int DP = 3;
    localparam int LW = LS * BW;
    localparam int CW = $clog2(DP + 1);

    logic          clk;
    logic          rstn;
    logic          flush;
    logic          wr_start;
    logic          wr_commit;
    logic          wr_open;
    logic [LS-1:0] weA, weB;
    logic [AW-1:0] waddrA, waddrB;
    logic [LW-1:0] dinA, dinB;
    logic          full;
    logic          rd_en;
    logic [AW-1:0] raddrA, raddrB;
    logic          rd_release;
    logic [LW-1:0] doutA, doutB;
    logic          rd_valid;
    logic          empty;
    logic [CW-1:0] count;
    logic          err_ovf;
    logic          err_udf;

    int n_checks = 0;
    int n_errors = 0;

    poly_slot_fifo #(
        .BIT_WIDTH (BW),
        .LINE_SIZE (LS),
        .ADDR_WIDTH(AW),
        .DEPTH     (DP)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .wr_start  (wr_start),
        .wr_commit (wr_commit),
        .wr_open   (wr_open),
        .weA       (weA),
        .weB       (weB),
        .waddrA    (waddrA),
        .waddrB    (waddrB),
        .dinA      (dinA),
        .dinB      (dinB),
        .full      (full),
        .rd_en     (rd_en),
        .raddrA    (raddrA),
        .raddrB    (raddrB),
        .rd_release(rd_release),
        .doutA     (doutA),
        .doutB     (doutB),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .count     (count),
        .err_ovf   (err_ovf),
        .err_udf   (err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_of(input logic [BW-1:0] v);
        return {LS{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; wr_start = 0; wr_commit = 0;
        weA = '0; weB = '0; waddrA = '0; waddrB = '0; dinA = '0; dinB = '0;
        rd_en = 0; raddrA = '0; raddrB = '0; rd_release = 0;
    endtask

    task automatic open_slot();
        wr_start = 1; tick(); wr_start = 0;
        check("wr_open after start", LW'(wr_open), LW'(1));
    endtask

    task automatic wr_line(input logic [AW-1:0] a, input logic [BW-1:0] v, input logic commit);
        weA = '1; waddrA = a; dinA = line_of(v); wr_commit = commit;
        tick();
        weA = '0; wr_commit = 0;
    endtask

    task automatic rd_line(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] exp);
        rd_en = 1; raddrA = a; raddrB = a;
        tick();
        rd_en = 0;
        check({tag, " valid"}, LW'(rd_valid), LW'(1));
        check({tag, " doutA"}, doutA, exp);
        check({tag, " doutB"}, doutB, exp);
    endtask

    initial begin
        idle();
        rstn = 0;
        tick(); tick();
        check("reset wr_open",  LW'(wr_open),  LW'(0));
        check("reset count",    LW'(count),    LW'(0));
        check("reset empty",    LW'(empty),    LW'(1));
        check("reset full",     LW'(full),     LW'(0));
        check("reset rd_valid", LW'(rd_valid), LW'(0));
        check("reset doutA",    doutA,         '0);
        check("reset err_ovf",  LW'(err_ovf),  LW'(0));
        check("reset err_udf",  LW'(err_udf),  LW'(0));
        rstn = 1;
        tick();

        // Slot 0: line i = i in every word; last line written in the commit cycle.
        open_slot();
        for (int i = 0; i < 256; i++) wr_line(AW'(i), BW'(i), i == 255);
        check("slot0 closed", LW'(wr_open), LW'(0));
        check("slot0 count",  LW'(count),   LW'(1));
        check("slot0 empty",  LW'(empty),   LW'(0));
        for (int i = 0; i < 256; i++) begin
            rd_en = 1; raddrA = AW'(i); raddrB = AW'(255 - i);
            tick();
            check("bulk valid", LW'(rd_valid), LW'(1));
            check("bulk doutA", doutA, line_of(BW'(i)));
            check("bulk doutB", doutB, line_of(BW'(255 - i)));
        end
        rd_en = 0;
        tick();
        check("idle rd_valid", LW'(rd_valid), LW'(0));
        check("dout hold",     doutA,         line_of(BW'(255)));
        check("count still 1", LW'(count),    LW'(1));

        // Slot 1: per-word enables and same-word collision (B wins).
        open_slot();
        weA = 4'b0101; waddrA = 5; dinA = line_of(1); tick(); weA = '0;
        weB = 4'b1010; waddrB = 5; dinB = line_of(2); tick(); weB = '0;
        weA = '1; waddrA = 6; dinA = line_of(3);
        weB = '1; waddrB = 6; dinB = line_of(4); tick();
        weA = '0; weB = '0;
        wr_line(0, 32'h10, 1'b1);
        check("slot1 count", LW'(count), LW'(2));
        rd_release = 1; tick(); rd_release = 0;
        check("release count", LW'(count), LW'(1));
        rd_line("wordsel", 5, {32'd2, 32'd1, 32'd2, 32'd1});
        rd_line("collide", 6, line_of(4));

        // Slot 2 then slot 0 (write pointer wraps) -> full.
        open_slot();
        wr_line(0, 32'h20, 1'b1);
        open_slot();
        wr_line(0, 32'h30, 1'b1);
        check("full flag",  LW'(full),  LW'(1));
        check("full count", LW'(count), LW'(3));
        wr_start = 1; tick(); wr_start = 0;
        check("ovf wr_open", LW'(wr_open), LW'(0));
        check("ovf flag",    LW'(err_ovf), LW'(1));
        check("ovf count",   LW'(count),   LW'(3));

        // Pop slot 1, refill it, then commit + release + read in one cycle.
        rd_release = 1; tick(); rd_release = 0;
        check("pre-wrap count", LW'(count), LW'(2));
        open_slot();
        weA = '1; waddrA = 0; dinA = line_of(32'h40);
        wr_commit = 1; rd_release = 1; rd_en = 1; raddrA = 0; raddrB = 0;
        tick();
        idle();
        check("both count",    LW'(count),    LW'(2));
        check("old head valid", LW'(rd_valid), LW'(1));
        check("old head data", doutA,         line_of(32'h20));
        rd_line("wrapped head", 0, line_of(32'h30));
        rd_release = 1; tick(); rd_release = 0;
        rd_line("refilled slot1", 0, line_of(32'h40));
        rd_line("slot1 old line", 5, {32'd2, 32'd1, 32'd2, 32'd1});
        rd_release = 1; tick(); rd_release = 0;
        check("drained empty", LW'(empty), LW'(1));

        // Underflow on empty.
        rd_release = 1; rd_en = 1; tick(); idle();
        check("udf count",    LW'(count),    LW'(0));
        check("udf rd_valid", LW'(rd_valid), LW'(0));
        check("udf flag",     LW'(err_udf),  LW'(1));
        check("udf hold",     doutA,         {32'd2, 32'd1, 32'd2, 32'd1});

        // Flush discards a partially written slot 2.
        open_slot();
        for (int i = 0; i < 10; i++) wr_line(AW'(i), BW'(32'h50 + i), 1'b0);
        flush = 1; tick(); flush = 0;
        check("flush wr_open", LW'(wr_open), LW'(0));
        check("flush count",   LW'(count),   LW'(0));
        check("flush empty",   LW'(empty),   LW'(1));
        check("flush err_ovf", LW'(err_ovf), LW'(0));
        check("flush err_udf", LW'(err_udf), LW'(0));
        check("flush doutA",   doutA,        '0);

        // After flush the next slot is slot 0 again: its old lines remain.
        open_slot();
        wr_line(0, 32'h60, 1'b1);
        check("post-flush count", LW'(count), LW'(1));
        rd_line("post-flush line0", 0, line_of(32'h60));
        rd_line("post-flush line9", 9, line_of(32'd9));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
